// File: rtl/cmos_capture.sv
// CMOS sensor capture: registers the 8-bit sensor bus, frames on VSYNC/HREF and packs byte pairs into RGB565 words.
// Optional line/frame statistics are built when CMOS_CAPTURE_STATS_EN is defined.
`timescale 1ns/1ps
module cmos_capture #(
  parameter int FRAME_SKIP = 2,
  parameter int H_PIX      = 1024,
  parameter int V_LINES    = 720
) (
  input  logic        cmos_pclk,
  input  logic        RST,
  input  logic        cmos_vsyn,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        fifo_full,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        overflow,
  output logic [15:0] line_cnt,
  output logic        size_err
);

  typedef enum logic [1:0] {IDLE, VBLANK, SKIP, ACTIVE} state_t;

  localparam logic [7:0] SKIP_N = 8'(FRAME_SKIP);

  logic       vs_r, vs_r1, hr_r;
  logic [7:0] d_r;
  state_t     state, state_nx;
  logic       start_nx, end_nx, skip_inc;
  logic [7:0] skip_cnt;
  logic       ph;
  logic [7:0] hi;
  logic       vs_fall, vs_rise, pack_en, pix_slot;

  assign vs_fall  = vs_r1 & ~vs_r;
  assign vs_rise  = ~vs_r1 & vs_r;
  // A vs rise aborts packing so any half pixel is thrown away.
  assign pack_en  = (state == ACTIVE) && !vs_rise;
  assign pix_slot = pack_en && hr_r && ph;

  // Input register stage
  always_ff @(posedge cmos_pclk) begin
    if (RST) begin
      vs_r  <= 1'b0;
      vs_r1 <= 1'b0;
      hr_r  <= 1'b0;
      d_r   <= 8'd0;
    end else begin
      vs_r  <= cmos_vsyn;
      vs_r1 <= vs_r;
      hr_r  <= cmos_href;
      d_r   <= cmos_data;
    end
  end

  // Frame state register
  always_ff @(posedge cmos_pclk) begin
    if (RST) begin
      state       <= IDLE;
      skip_cnt    <= 8'd0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_start <= start_nx;
      frame_end   <= end_nx;
      if (skip_inc) skip_cnt <= skip_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    end_nx   = 1'b0;
    skip_inc = 1'b0;
    case (state)
      IDLE: begin
        if (vs_r) state_nx = VBLANK;
      end
      VBLANK: begin
        if (vs_fall) begin
          if (skip_cnt < SKIP_N) begin
            skip_inc = 1'b1;
            state_nx = SKIP;
          end else begin
            start_nx = 1'b1;
            state_nx = ACTIVE;
          end
        end
      end
      SKIP: begin
        if (vs_rise) state_nx = VBLANK;
      end
      ACTIVE: begin
        if (vs_rise) begin
          end_nx   = 1'b1;
          state_nx = VBLANK;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte-pair packing stage
  always_ff @(posedge cmos_pclk) begin
    if (RST) begin
      ph        <= 1'b0;
      hi        <= 8'd0;
      pix_data  <= 16'd0;
      pix_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (!pack_en || !hr_r) begin
        ph <= 1'b0;
      end else if (!ph) begin
        hi <= d_r;
        ph <= 1'b1;
      end else begin
        ph <= 1'b0;
        if (fifo_full) begin
          overflow <= 1'b1;
        end else begin
          pix_valid <= 1'b1;
          pix_data  <= {hi, d_r};
        end
      end
    end
  end

`ifdef CMOS_CAPTURE_STATS_EN
  localparam logic [15:0] H_N = 16'(H_PIX);
  localparam logic [15:0] V_N = 16'(V_LINES);

  logic        hr_r1;
  logic [15:0] pcnt, lines;
  logic        serr;
  logic        hr_rise, hr_fall;

  assign hr_rise = pack_en && hr_r && !hr_r1;
  assign hr_fall = pack_en && !hr_r && hr_r1;

  // Line / frame size statistics
  always_ff @(posedge cmos_pclk) begin
    if (RST) begin
      hr_r1 <= 1'b0;
      pcnt  <= 16'd0;
      lines <= 16'd0;
      serr  <= 1'b0;
    end else begin
      hr_r1 <= hr_r;
      if (start_nx) lines <= 16'd0;
      else if (hr_fall) lines <= lines + 16'd1;
      if (hr_rise) pcnt <= 16'd0;
      else if (pix_slot) pcnt <= pcnt + 16'd1;
      // ph still set at the falling edge means a trailing odd byte was dropped.
      if (hr_fall && (pcnt != H_N || ph)) serr <= 1'b1;
      if (end_nx && lines != V_N) serr <= 1'b1;
    end
  end

  assign line_cnt = lines;
  assign size_err = serr;
`else
  assign line_cnt = 16'd0;
  assign size_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_capture.sv
// Self-checking bench for cmos_capture: directed pixel table plus random frames against a queue-based model.
`timescale 1ns/1ps
module tb_cmos_capture;

  localparam int FS = 2;
  localparam int HP = 8;
  localparam int VL = 4;
`ifdef CMOS_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vsyn, href, ff;
  logic [7:0]  data;
  logic [15:0] pix_data, line_cnt;
  logic        pix_valid, frame_start, frame_end, overflow, size_err;

  cmos_capture #(.FRAME_SKIP(FS), .H_PIX(HP), .V_LINES(VL)) dut (
    .cmos_pclk  (clk),
    .RST        (rst),
    .cmos_vsyn  (vsyn),
    .cmos_href  (href),
    .cmos_data  (data),
    .fifo_full  (ff),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .overflow   (overflow),
    .line_cnt   (line_cnt),
    .size_err   (size_err)
  );

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        full;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;
  vec_t tbl [5];

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int m_skip;
  bit cap;

  int consec = 0;
  int ord_err = 0;
  bit prev_v = 1'b0;
  bit in_frame = 1'b0;
  logic [15:0] fe_line = 16'd0;
  logic fe_serr = 1'b0;

  always @(negedge clk) begin
    if (pix_valid) begin
      got_q.push_back(pix_data);
      if (prev_v) consec <= consec + 1;
      if (!in_frame) ord_err <= ord_err + 1;
    end
    if (frame_start) in_frame <= 1'b1;
    if (frame_end) begin
      in_frame <= 1'b0;
      fe_line  <= line_cnt;
      fe_serr  <= size_err;
    end
    prev_v <= pix_valid;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks want completion", check_cnt);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " pix_data"},    32'(pix_data),    32'd0);
    chk({tag, " pix_valid"},   32'(pix_valid),   32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, " frame_end"},   32'(frame_end),   32'd0);
    chk({tag, " overflow"},    32'(overflow),    32'd0);
    chk({tag, " line_cnt"},    32'(line_cnt),    32'd0);
    chk({tag, " size_err"},    32'(size_err),    32'd0);
  endtask

  // Each line: bytes at cycles 0..n-1, pair k completes and is written at cycle 2k+2
  // unless fifo_full is high in that cycle.
  task automatic send_line(input int nbytes, input int ff_lo, input int ff_hi);
    logic [7:0] b[$];
    logic [7:0] v;
    for (int c = 0; c < nbytes + 4; c++) begin
      v    = 8'($urandom);
      href = (c < nbytes);
      data = v;
      ff   = (c >= ff_lo && c <= ff_hi);
      if (c < nbytes) b.push_back(v);
      if (cap && c >= 2 && (c % 2) == 0 && c <= nbytes && !ff)
        exp_q.push_back({b[c-2], b[c-1]});
      @(negedge clk);
    end
    href = 1'b0;
    ff   = 1'b0;
  endtask

  task automatic frame_open();
    vsyn = 1'b1;
    href = 1'b0;
    repeat (4) @(negedge clk);
    vsyn = 1'b0;
    cap  = 1'b0;
    if (m_skip < FS) m_skip++;
    else cap = 1'b1;
    @(negedge clk);
    chk("frame_start early", 32'(frame_start), 32'd0);
    @(negedge clk);
    chk("frame_start", 32'(frame_start), 32'(cap));
    @(negedge clk);
  endtask

  task automatic frame_close();
    vsyn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("frame_end", 32'(frame_end), 32'(cap));
    cap = 1'b0;
  endtask

  task automatic full_frame(input int nlines, input int odd_idx);
    frame_open();
    for (int l = 0; l < nlines; l++)
      send_line((l == odd_idx) ? 2 * HP - 1 : 2 * HP, 999, -1);
    frame_close();
  endtask

  task automatic cmp_q(input string name);
    repeat (3) @(negedge clk);
    chk({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk(name, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 16'hA53C};
    tbl[1] = '{8'h00, 8'hFF, 1'b0, 1'b1, 16'h00FF};
    tbl[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 16'hFF00};
    tbl[3] = '{8'h12, 8'h34, 1'b1, 1'b0, 16'h0000};
    tbl[4] = '{8'h5A, 8'hC3, 1'b0, 1'b1, 16'h5AC3};

    rst = 1'b1; vsyn = 1'b0; href = 1'b0; ff = 1'b0; data = 8'd0;
    m_skip = 0; cap = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Two settling frames dropped, then two captured frames.
    repeat (4) full_frame(VL, -1);
    cmp_q("frame pixels");
    chk("overflow clean", 32'(overflow), 32'd0);
    chk("size_err clean", 32'(size_err), 32'd0);

    // Directed byte pairs, one per 2-byte line, with exact latency.
    frame_open();
    for (int i = 0; i < 5; i++) begin
      href = 1'b1; data = tbl[i].hi;
      @(negedge clk);
      data = tbl[i].lo;
      @(negedge clk);
      href = 1'b0; ff = tbl[i].full;
      chk("valid before latency", 32'(pix_valid), 32'd0);
      @(negedge clk);
      ff = 1'b0;
      chk("table valid", 32'(pix_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("table data", 32'(pix_data), 32'(tbl[i].exp_d));
      repeat (2) @(negedge clk);
    end
    chk("overflow after drop", 32'(overflow), 32'd1);
    repeat (2) @(negedge clk);
    got_q.delete();
    // fifo_full across three write slots mid-line.
    send_line(2 * HP, 5, 10);
    send_line(2 * HP, 999, -1);
    frame_close();
    cmp_q("fifo_full line");
    chk("overflow sticky", 32'(overflow), 32'd1);

    // Reset pulse in the middle of a captured frame.
    frame_open();
    send_line(2 * HP, 999, -1);
    chk("overflow before reset", 32'(overflow), 32'd1);
    href = 1'b1; data = 8'h77; rst = 1'b1;
    m_skip = 0; cap = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero_outputs("mid reset");
    for (int l = 0; l < VL - 1; l++) send_line(2 * HP, 999, -1);
    frame_close();
    repeat (3) full_frame(VL, -1);
    cmp_q("after reset");
    chk("overflow cleared", 32'(overflow), 32'd0);

    // Short frame: one line missing.
    chk("size_err before short", 32'(size_err), 32'd0);
    full_frame(VL - 1, -1);
    chk("line_cnt at short end", 32'(fe_line), STATS ? 32'(VL - 1) : 32'd0);
    chk("size_err short frame", 32'(fe_serr), STATS ? 32'd1 : 32'd0);
    cmp_q("short frame");

    // Odd-length line followed by realigned lines.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_skip = 0; cap = 1'b0;
    repeat (2) full_frame(VL, -1);
    full_frame(VL, 1);
    cmp_q("odd line");
    chk("size_err odd line", 32'(size_err), STATS ? 32'd1 : 32'd0);
    chk("line_cnt odd frame", 32'(fe_line), STATS ? 32'(VL) : 32'd0);
    chk("overflow odd frame", 32'(overflow), 32'd0);
    chk("back-to-back valid", 32'(consec), 32'd0);
    chk("valid outside frame", 32'(ord_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
